// File: rtl/aes_inverse_cipher_iter.sv
// Iterative AES inverse cipher: one inverse-round datapath reused per cycle,
// round keys fetched by index from an external combinational key store.
module aes_inverse_cipher_iter #(
    parameter int unsigned NR     = 10,
    parameter int unsigned KIDX_W = 4
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [127:0]        i_in_data,
    output logic [KIDX_W-1:0]   o_key_idx,
    input  logic [127:0]        i_key_in,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [127:0]        o_out_data,
    output logic                o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_e;

    localparam logic [KIDX_W-1:0] NR_K = KIDX_W'(NR);

    state_e              r_state;
    logic [KIDX_W-1:0]   r_rc;
    logic [127:0]        r_st;
    logic                r_out_valid;
    logic [127:0]        r_out_data;
    logic [127:0]        w_core;
    logic [127:0]        w_mix;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // Byte n = row + 4*col, byte 0 in the top bits.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++)
            o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   b0, b1, b2, b3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            b0 = s[127-8*(4*c)   -: 8];
            b1 = s[127-8*(4*c+1) -: 8];
            b2 = s[127-8*(4*c+2) -: 8];
            b3 = s[127-8*(4*c+3) -: 8];
            o[127-8*(4*c)   -: 8] = gf_mul(b0, 8'h0e) ^ gf_mul(b1, 8'h0b) ^ gf_mul(b2, 8'h0d) ^ gf_mul(b3, 8'h09);
            o[127-8*(4*c+1) -: 8] = gf_mul(b0, 8'h09) ^ gf_mul(b1, 8'h0e) ^ gf_mul(b2, 8'h0b) ^ gf_mul(b3, 8'h0d);
            o[127-8*(4*c+2) -: 8] = gf_mul(b0, 8'h0d) ^ gf_mul(b1, 8'h09) ^ gf_mul(b2, 8'h0e) ^ gf_mul(b3, 8'h0b);
            o[127-8*(4*c+3) -: 8] = gf_mul(b0, 8'h0b) ^ gf_mul(b1, 8'h0d) ^ gf_mul(b2, 8'h09) ^ gf_mul(b3, 8'h0e);
        end
        return o;
    endfunction

    // Inverse round datapath: final round takes w_core, others take w_mix.
    always_comb begin
        w_core = inv_sub_bytes(inv_shift_rows(r_st)) ^ i_key_in;
        w_mix  = inv_mix_columns(w_core);
    end

    // Round-key index requested from the key store.
    always_comb begin
        o_key_idx = '0;
        case (r_state)
            S_IDLE:  o_key_idx = NR_K;
            S_ROUND: o_key_idx = NR_K - r_rc;
            default: o_key_idx = '0;
        endcase
    end

    assign o_in_ready  = (r_state == S_IDLE) && !i_reset;
    assign o_busy      = (r_state != S_IDLE);
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

    // Control FSM with round counter, state register and output registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_rc        <= '0;
            r_st        <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_st    <= i_in_data ^ i_key_in;
                        r_rc    <= KIDX_W'(1);
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (r_rc == NR_K) begin
                        r_out_data  <= w_core;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_st <= w_mix;
                        r_rc <= r_rc + KIDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inverse_cipher_iter.sv
// Scoreboard bench for aes_inverse_cipher_iter using FIPS-197 vectors.
module tb_aes_inverse_cipher_iter;

    localparam int unsigned NR = 10;

    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   key_idx;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic [127:0] rk1 [16];
    logic [127:0] rk2 [16];
    bit           key_sel;

    logic [127:0] exp_q [$];
    logic [3:0]   kq [$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           rise_cnt = 0;
    int           rise_cyc = 0;
    int           hs_cnt  = 0;
    logic         prev_ov = 1'b0;

    always #5 clk = ~clk;

    assign key_in = key_sel ? rk2[key_idx] : rk1[key_idx];

    aes_inverse_cipher_iter #(.NR(NR), .KIDX_W(4)) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_in_data  (in_data),
        .o_key_idx  (key_idx),
        .i_key_in   (key_in),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_out_data (out_data),
        .o_busy     (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Forward S-box for the key schedule: inversion then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        for (int i = 1; i < 256; i++)
            if (gmul(a, 8'(i)) == 8'h01) inv = 8'(i);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic expand(input logic [127:0] key, input bit sel);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (sel) rk2[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
            else     rk1[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: scoreboard pop on handshake, rise tracking, key index log.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov <= 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                rise_cnt <= rise_cnt + 1;
                rise_cyc <= cyc;
            end
            prev_ov <= out_valid;
            if (busy && !out_valid) kq.push_back(key_idx);
            if (out_valid && out_ready) begin
                hs_cnt <= hs_cnt + 1;
                if (exp_q.size() == 0) check("unexpected_out", 128'(out_valid), 128'd0);
                else                   check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    // Offer a block (caller is just after a posedge) and return the accept cycle.
    task automatic send(input logic [127:0] ct, input logic [127:0] exp, input bit push,
                        output int acc);
        bit found = 1'b0;
        in_valid = 1'b1;
        in_data  = ct;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (in_ready) found = 1'b1;
        end
        check("accept_timeout", 128'(found), 128'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        in_valid = 1'b0;
        if (push && found) exp_q.push_back(exp);
    endtask

    task automatic wait_out();
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("out_valid_timeout", 128'(seen), 128'd1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && in_ready) done = 1'b1;
        end
        check("idle_timeout", 128'(done), 128'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        int b;
        int r0;
        int h0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; key_sel = 1'b0;
        expand(KEY1, 1'b0);
        expand(KEY2, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 128'(in_ready), 128'd1);
        check("idle_key_idx", 128'(key_idx), 128'(NR));
        @(posedge clk); #1;

        // T1: App.B vector and latency
        send(CT1, PT1, 1'b1, a);
        wait_idle();
        check("t1_latency", 128'(rise_cyc - a), 128'(NR));

        // T2: App.C.1 vector and key index order
        key_sel = 1'b1;
        kq.delete();
        send(CT2, PT2, 1'b1, a);
        wait_idle();
        check("t2_kidx_count", 128'(kq.size()), 128'd10);
        for (int i = 0; i < kq.size() && i < 10; i++)
            check("t2_kidx", 128'(kq[i]), 128'(9 - i));

        // T3: backpressure for 20 cycles
        key_sel = 1'b0;
        out_ready = 1'b0;
        send(CT1, PT1, 1'b1, a);
        wait_out();
        for (int i = 0; i < 20; i++) begin
            check("t3_hold_valid", 128'(out_valid), 128'd1);
            check("t3_hold_data", out_data, PT1);
            check("t3_hold_in_ready", 128'(in_ready), 128'd0);
            check("t3_hold_busy", 128'(busy), 128'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        h0 = hs_cnt;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_rel_valid", 128'(out_valid), 128'd0);
        check("t3_rel_in_ready", 128'(in_ready), 128'd1);
        check("t3_rel_busy", 128'(busy), 128'd0);
        repeat (3) @(negedge clk);
        check("t3_one_handshake", 128'(hs_cnt - h0), 128'd1);
        @(posedge clk); #1;

        // T4: second block offered during ROUND is held off until IDLE
        send(CT1, PT1, 1'b1, a);
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = CT2;
        wait_out();
        @(posedge clk); #1;
        key_sel = 1'b1;
        send(CT2, PT2, 1'b1, b);
        check("t4_second_accept", 128'(b - a), 128'(NR + 2));
        wait_idle();

        // T5: reset at rc=5 discards the block
        key_sel = 1'b0;
        r0 = rise_cnt;
        send(CT1, PT1, 1'b0, a);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t5_rst_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t5_post_in_ready", 128'(in_ready), 128'd1);
        check("t5_post_busy", 128'(busy), 128'd0);
        repeat (15) @(negedge clk);
        check("t5_no_out_valid", 128'(rise_cnt - r0), 128'd0);
        @(posedge clk); #1;
        key_sel = 1'b1;
        send(CT2, PT2, 1'b1, a);
        wait_idle();

        // T6: back-to-back blocks, second accepted NR+2 cycles later
        key_sel = 1'b0;
        send(CT1, PT1, 1'b1, a);
        in_valid = 1'b1;
        in_data  = CT2;
        wait_out();
        @(posedge clk); #1;
        key_sel = 1'b1;
        send(CT2, PT2, 1'b1, b);
        check("t6_accept_gap", 128'(b - a), 128'(NR + 2));
        wait_idle();
        check("t6_queue_empty", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
